// File: rtl/bmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bmem_pkg
// Description : Shared widths, FSM/requester encodings and the line-align
//               helper for the cache-to-bmem line adapter.
// Revision    : 1.0 - initial release
// ============================================================================
package bmem_pkg;

   localparam int LINE_W     = 256;
   localparam int BEAT_W     = 64;
   localparam int BEATS      = LINE_W / BEAT_W;
   localparam int OFFSET_W   = 5;
   localparam int BEAT_IDX_W = $clog2(BEATS);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_CMD  = 3'd1,
      RD_DATA = 3'd2,
      WR_DATA = 3'd3,
      DONE    = 3'd4
   } adapter_state_t;

   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } req_src_t;

   function automatic logic [31:0] line_align(input logic [31:0] addr);
      line_align = {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
   endfunction

endpackage
`default_nettype wire

// File: rtl/bmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bmem_arbiter
// Description : Two-requester (icache/dcache) grant logic. The registered
//               last_grant doubles as the owner of the transaction in flight.
//               BMEM_ARB_RR_EN selects round-robin; default is fixed dcache
//               priority.
// Revision    : 1.0 - initial release
// ============================================================================
module bmem_arbiter
   import bmem_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_i,
   input  logic req_d,
   input  logic grant_en,
   output logic grant_d,
   output logic owner_d
);

   req_src_t r_last_grant;
   logic     w_grant_d;

`ifdef BMEM_ARB_RR_EN
   // On contention, favour whichever side was not served last.
   always_comb begin
      w_grant_d = req_d;
      if (req_i && req_d) begin
         w_grant_d = (r_last_grant == SRC_I);
      end
   end
`else
   assign w_grant_d = req_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= SRC_I;
      end else if (grant_en && (req_i || req_d)) begin
         r_last_grant <= w_grant_d ? SRC_D : SRC_I;
      end
   end

   assign grant_d = w_grant_d;
   assign owner_d = (r_last_grant == SRC_D);

endmodule
`default_nettype wire

// File: rtl/bmem_line_adapter.sv
`default_nettype none
// ============================================================================
// Module      : bmem_line_adapter
// Description : Bridges icache/dcache line requests onto the 64-bit burst
//               bmem port, one transaction at a time. Arbitration mode is
//               chosen by BMEM_ARB_RR_EN (see bmem_arbiter).
// Revision    : 1.0 - initial release
// ============================================================================
module bmem_line_adapter
   import bmem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,

   input  logic [31:0]       i_addr,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,

   input  logic [31:0]       d_addr,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,

   output logic [31:0]       bmem_addr,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [BEAT_W-1:0] bmem_wdata,
   input  logic              bmem_ready,
   input  logic [31:0]       bmem_raddr,
   input  logic [BEAT_W-1:0] bmem_rdata,
   input  logic              bmem_rvalid
);

   localparam logic [BEAT_IDX_W-1:0] C_LAST_BEAT = BEAT_IDX_W'(BEATS - 1);
   localparam logic [BEAT_IDX_W-1:0] C_BEAT_ONE  = BEAT_IDX_W'(1);

   adapter_state_t          r_state;
   adapter_state_t          w_state_next;
   logic [BEAT_IDX_W-1:0]   r_beat;
   logic [31:0]             r_req_addr;
   logic [LINE_W-1:0]       r_line;
   logic [LINE_W-1:0]       r_i_rdata;
   logic [LINE_W-1:0]       r_d_rdata;
   logic [LINE_W-1:0]       w_line_fill;

   logic w_idle;
   logic w_req_d;
   logic w_req_any;
   logic w_grant_d;
   logic w_owner_d;
   logic w_rd_hit;
   logic w_last_beat;

   assign w_idle      = (r_state == IDLE);
   assign w_req_d     = d_read | d_write;
   assign w_req_any   = i_read | w_req_d;
   assign w_rd_hit    = bmem_rvalid && (bmem_raddr == r_req_addr);
   assign w_last_beat = (r_beat == C_LAST_BEAT);

   bmem_arbiter u_arbiter (
      .clk      (clk),
      .rst      (rst),
      .req_i    (i_read),
      .req_d    (w_req_d),
      .grant_en (w_idle),
      .grant_d  (w_grant_d),
      .owner_d  (w_owner_d)
   );

   // Assembly buffer with the incoming beat merged at the current slot.
   always_comb begin
      w_line_fill = r_line;
      w_line_fill[BEAT_W*r_beat +: BEAT_W] = bmem_rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      bmem_read    = 1'b0;
      bmem_write   = 1'b0;
      bmem_addr    = '0;
      bmem_wdata   = '0;
      i_resp       = 1'b0;
      d_resp       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req_any) begin
               // d_write wins over a simultaneous (illegal) d_read.
               w_state_next = (w_grant_d && d_write) ? WR_DATA : RD_CMD;
            end
         end
         RD_CMD: begin
            bmem_read = 1'b1;
            bmem_addr = r_req_addr;
            if (bmem_ready) begin
               w_state_next = RD_DATA;
            end
         end
         RD_DATA: begin
            if (w_rd_hit && w_last_beat) begin
               w_state_next = DONE;
            end
         end
         WR_DATA: begin
            bmem_write = 1'b1;
            bmem_addr  = r_req_addr;
            bmem_wdata = r_line[BEAT_W*r_beat +: BEAT_W];
            if (bmem_ready && w_last_beat) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            i_resp       = ~w_owner_d;
            d_resp       = w_owner_d;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beat     <= '0;
         r_req_addr <= '0;
         r_line     <= '0;
         r_i_rdata  <= '0;
         r_d_rdata  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req_any) begin
                  r_beat <= '0;
                  if (w_grant_d) begin
                     r_req_addr <= line_align(d_addr);
                     if (d_write) begin
                        r_line <= d_wdata;
                     end
                  end else begin
                     r_req_addr <= line_align(i_addr);
                  end
               end
            end
            RD_DATA: begin
               if (w_rd_hit) begin
                  r_line <= w_line_fill;
                  r_beat <= r_beat + C_BEAT_ONE;
                  // Publish the finished line so it is valid in the DONE cycle.
                  if (w_last_beat) begin
                     if (w_owner_d) begin
                        r_d_rdata <= w_line_fill;
                     end else begin
                        r_i_rdata <= w_line_fill;
                     end
                  end
               end
            end
            WR_DATA: begin
               if (bmem_ready) begin
                  r_beat <= r_beat + C_BEAT_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign i_rdata = r_i_rdata;
   assign d_rdata = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bmem_line_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bmem_line_adapter
// Description : Scoreboard bench for bmem_line_adapter; bench acts as both
//               caches and the bmem memory. Honours BMEM_ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bmem_line_adapter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  i_addr = '0;
   logic         i_read = 1'b0;
   logic [255:0] i_rdata;
   logic         i_resp;
   logic [31:0]  d_addr = '0;
   logic         d_read = 1'b0;
   logic         d_write = 1'b0;
   logic [255:0] d_wdata = '0;
   logic [255:0] d_rdata;
   logic         d_resp;
   logic [31:0]  bmem_addr;
   logic         bmem_read;
   logic         bmem_write;
   logic [63:0]  bmem_wdata;
   logic         bmem_ready = 1'b0;
   logic [31:0]  bmem_raddr = '0;
   logic [63:0]  bmem_rdata = '0;
   logic         bmem_rvalid = 1'b0;

   typedef struct {
      bit           is_d;
      bit           is_wr;
      logic [255:0] data;
   } exp_t;

   exp_t        resp_q[$];
   logic [63:0] wbeat_q[$];
   exp_t        sb_e;
   int          n_cmp = 0;
   int          n_err = 0;

   bmem_line_adapter dut (
      .clk         (clk),
      .rst         (rst),
      .i_addr      (i_addr),
      .i_read      (i_read),
      .i_rdata     (i_rdata),
      .i_resp      (i_resp),
      .d_addr      (d_addr),
      .d_read      (d_read),
      .d_write     (d_write),
      .d_wdata     (d_wdata),
      .d_rdata     (d_rdata),
      .d_resp      (d_resp),
      .bmem_addr   (bmem_addr),
      .bmem_read   (bmem_read),
      .bmem_write  (bmem_write),
      .bmem_wdata  (bmem_wdata),
      .bmem_ready  (bmem_ready),
      .bmem_raddr  (bmem_raddr),
      .bmem_rdata  (bmem_rdata),
      .bmem_rvalid (bmem_rvalid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Completion scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (bmem_read && bmem_write) begin
            check("rw_exclusive", 256'd1, 256'd0);
         end
         if (i_resp || d_resp) begin
            if (resp_q.size() == 0) begin
               check("resp_unexpected", {254'd0, i_resp, d_resp}, 256'd0);
            end else begin
               sb_e = resp_q.pop_front();
               check("resp_src", {254'd0, i_resp, d_resp}, sb_e.is_d ? 256'd1 : 256'd2);
               if (!sb_e.is_wr) begin
                  check("resp_line", sb_e.is_d ? d_rdata : i_rdata, sb_e.data);
               end
            end
         end
      end
   end

   task automatic push_resp(input bit is_d, input bit is_wr, input logic [255:0] data);
      exp_t e;
      e.is_d  = is_d;
      e.is_wr = is_wr;
      e.data  = data;
      resp_q.push_back(e);
   endtask

   function automatic logic [255:0] mk_line(input logic [7:0] seed);
      logic [255:0] l;
      for (int b = 0; b < 4; b++) begin
         l[64*b +: 64] = {8{seed + 8'(b)}};
      end
      return l;
   endfunction

   // Memory side of a read: accept the command, then return four beats.
   task automatic serve_read(input logic [31:0] addr, input logic [255:0] line, input bit bad);
      int n = 0;
      while (!bmem_read && n < 50) begin
         tick();
         n++;
      end
      if (!bmem_read) begin
         check("rd_cmd_timeout", 256'd0, 256'd1);
         return;
      end
      check("rd_addr", {224'd0, bmem_addr}, {224'd0, addr});
      bmem_ready = 1'b1;
      tick();
      bmem_ready = 1'b0;
      tick();
      tick();
      for (int b = 0; b < 4; b++) begin
         if (bad && b == 2) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'hDEAD_0000;
            bmem_rdata  = 64'hBADB_ADBA_DBAD_BADB;
            tick();
         end
         bmem_rvalid = 1'b1;
         bmem_raddr  = addr;
         bmem_rdata  = line[64*b +: 64];
         tick();
      end
      bmem_rvalid = 1'b0;
      bmem_raddr  = '0;
      bmem_rdata  = '0;
   endtask

   // Memory side of a write, optionally stalling one beat.
   task automatic serve_write(input logic [31:0] addr, input int stall_beat, input int stall_cycles);
      int n = 0;
      logic [63:0] exp_beat;
      while (!bmem_write && n < 50) begin
         tick();
         n++;
      end
      if (!bmem_write) begin
         check("wr_cmd_timeout", 256'd0, 256'd1);
         return;
      end
      check("wr_addr", {224'd0, bmem_addr}, {224'd0, addr});
      for (int b = 0; b < 4; b++) begin
         if (b == stall_beat) begin
            for (int s = 0; s < stall_cycles; s++) begin
               bmem_ready = 1'b0;
               check("wr_hold", {191'd0, bmem_write, bmem_wdata}, {191'd0, 1'b1, wbeat_q[0]});
               tick();
            end
         end
         bmem_ready = 1'b1;
         exp_beat   = wbeat_q.pop_front();
         check("wr_beat", {191'd0, bmem_write, bmem_wdata}, {191'd0, 1'b1, exp_beat});
         tick();
      end
      bmem_ready = 1'b0;
      check("wr_resp_timing", {255'd0, d_resp}, 256'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_i_rdata"}, i_rdata, 256'd0);
      check({tag, "_d_rdata"}, d_rdata, 256'd0);
      check({tag, "_ctrl"}, {155'd0, bmem_addr, bmem_wdata, bmem_read, bmem_write, i_resp, d_resp},
            256'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] l1, lw, la, lb, l4, l5a, l5b, l6;
      logic [31:0]  addr_a, addr_b;
      bit           first_d;

      l1  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      lw  = mk_line(8'hA0);
      la  = mk_line(8'h50);
      lb  = mk_line(8'h60);
      l4  = mk_line(8'h40);
      l5a = mk_line(8'h70);
      l5b = mk_line(8'h80);
      l6  = mk_line(8'h30);

      // Reset state
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // icache read, unaligned address, no memory stalls
      push_resp(1'b0, 1'b0, l1);
      i_addr = 32'h0000_1004;
      i_read = 1'b1;
      serve_read(32'h0000_1000, l1, 1'b0);
      check("t1_i_resp", {255'd0, i_resp}, 256'd1);
      tick();
      i_read = 1'b0;

      // dcache writeback with beat 2 stalled for 3 cycles
      for (int b = 0; b < 4; b++) begin
         wbeat_q.push_back(lw[64*b +: 64]);
      end
      push_resp(1'b1, 1'b1, '0);
      d_addr  = 32'h0000_2040;
      d_wdata = lw;
      d_write = 1'b1;
      serve_write(32'h0000_2040, 2, 3);
      tick();
      d_write = 1'b0;
      check("t2_i_rdata_held", i_rdata, l1);

      // Simultaneous icache and dcache reads
`ifdef BMEM_ARB_RR_EN
      first_d = 1'b0;
`else
      first_d = 1'b1;
`endif
      addr_a = first_d ? 32'h0000_5000 : 32'h0000_6000;
      addr_b = first_d ? 32'h0000_6000 : 32'h0000_5000;
      push_resp(first_d, 1'b0, la);
      push_resp(!first_d, 1'b0, lb);
      d_addr = 32'h0000_5000 | (first_d ? 32'h0 : 32'h8);
      i_addr = 32'h0000_6010 & (first_d ? 32'hFFFF_FFFF : 32'hFFFF_FFF0);
      d_read = 1'b1;
      i_read = 1'b1;
      serve_read(addr_a, la, 1'b0);
      tick();
      if (first_d) d_read = 1'b0; else i_read = 1'b0;
      serve_read(addr_b, lb, 1'b0);
      tick();
      d_read = 1'b0;
      i_read = 1'b0;

      // Mismatched raddr beat interleaved mid-burst
      push_resp(1'b1, 1'b0, l4);
      d_addr = 32'h0000_401C;
      d_read = 1'b1;
      serve_read(32'h0000_4000, l4, 1'b1);
      check("t4_d_resp", {255'd0, d_resp}, 256'd1);
      tick();
      d_read = 1'b0;

      // Back-to-back dcache reads
      push_resp(1'b1, 1'b0, l5a);
      push_resp(1'b1, 1'b0, l5b);
      d_addr = 32'h0000_7000;
      d_read = 1'b1;
      serve_read(32'h0000_7000, l5a, 1'b0);
      tick();
      d_addr = 32'h0000_7100;
      check("b2b_no_cmd_after_done", {255'd0, bmem_read}, 256'd0);
      serve_read(32'h0000_7100, l5b, 1'b0);
      tick();
      d_read = 1'b0;
      tick();
      tick();
      check("b2b_quiet", {254'd0, bmem_read, bmem_write}, 256'd0);

      // Reset during RD_DATA after two beats
      i_addr = 32'h0000_3000;
      i_read = 1'b1;
      tick();
      check("t6_cmd", {255'd0, bmem_read}, 256'd1);
      bmem_ready = 1'b1;
      tick();
      bmem_ready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         bmem_rvalid = 1'b1;
         bmem_raddr  = 32'h0000_3000;
         bmem_rdata  = 64'hDEAD_BEEF_0000_0000 | 64'(b);
         tick();
      end
      bmem_rdata = 64'hDEAD_BEEF_0000_0002;
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      i_read = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      bmem_rvalid = 1'b0;
      bmem_raddr  = '0;
      bmem_rdata  = '0;
      check_all_zero("post_rst");

      push_resp(1'b0, 1'b0, l6);
      i_addr = 32'h0000_3008;
      i_read = 1'b1;
      serve_read(32'h0000_3000, l6, 1'b0);
      check("t6_i_resp", {255'd0, i_resp}, 256'd1);
      tick();
      i_read = 1'b0;

      for (int k = 0; k < 5; k++) begin
         tick();
      end
      check("sb_drained", 256'(resp_q.size()), 256'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bmem_line_adapter.md
Name: bmem_line_adapter

Overview:
- Sits inside cpu between the instruction/data caches and the banked memory port (bmem_*).
- Arbitrates between icache line reads and dcache line reads/writebacks.
- Serializes each 256-bit line into four 64-bit bursts on bmem_* and reassembles read bursts into a line.
- Exactly one transaction is outstanding at a time.

Parameters:
- LINE_W, 256, cache line width in bits
- BEAT_W, 64, bmem data beat width
- BEATS, 4, beats per line (LINE_W/BEAT_W)
- OFFSET_W, 5, line-offset bits zeroed on bmem_addr

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_addr  in  32  icache line address
- i_read  in  1  icache read request, held until i_resp
- i_rdata  out  256  icache fill line
- i_resp  out  1  icache completion pulse
- d_addr  in  32  dcache line address
- d_read  in  1  dcache read request, held until d_resp
- d_write  in  1  dcache writeback request, held until d_resp
- d_wdata  in  256  dcache writeback line
- d_rdata  out  256  dcache fill line
- d_resp  out  1  dcache completion pulse
- bmem_addr  out  32  burst address, line aligned
- bmem_read  out  1  burst read command
- bmem_write  out  1  burst write beat valid
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  memory accepts command/beat this cycle
- bmem_raddr  in  32  address tag of the returning read beat
- bmem_rdata  in  64  read beat data
- bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset: state IDLE; all outputs 0, including rdata registers, beat counter and grant.
- Reset mid-transaction: abandon the transaction immediately and return to IDLE. Late rvalid beats arriving afterwards are ignored because there is no pending address.
- FSM states: IDLE, RD_CMD, RD_DATA, WR_DATA, DONE.
- IDLE:
  - Sample requests and grant one: dcache wins over icache (fixed priority).
  - d_read and d_write together is illegal; d_write wins.
  - Latch req_addr = {addr[31:5], 5'b0}, the requester ID and, for writes, d_wdata.
  - Go to RD_CMD or WR_DATA.
- RD_CMD:
  - Drive bmem_read=1 and bmem_addr=req_addr.
  - Hold both until bmem_ready=1 in the same cycle, then go to RD_DATA.
- RD_DATA:
  - Each cycle with bmem_rvalid=1 and bmem_raddr==req_addr: store bmem_rdata into line bits [64*k +: 64], where k is the beat counter, then increment k.
  - rvalid with a mismatched raddr is ignored.
  - When the 4th beat is stored (k wraps from 3 to 0), go to DONE.
- WR_DATA:
  - Drive bmem_write=1, bmem_addr=req_addr and bmem_wdata=line[64*k +: 64].
  - k increments only on a cycle with bmem_ready=1. If ready is low, hold the same beat.
  - After beat 3 is accepted, go to DONE.
- DONE:
  - Pulse i_resp or d_resp (per requester ID) high for exactly one cycle.
  - i_rdata/d_rdata are valid that cycle and held until the next read for that requester completes.
  - Return to IDLE.
  - The requester drops its request in the cycle after resp, so IDLE must not re-grant the same request in the DONE+1 cycle: IDLE only grants requests sampled in IDLE.
- Latency, read with no memory stalls: 1 (IDLE) + 1 (RD_CMD) + memory latency + 4 beats + 1 (DONE).
- Latency, write: 1 + 4 + 1 = 6 cycles minimum.
- bmem_read and bmem_write are never high in the same cycle.

Optional Feature:
- Macro BMEM_ARB_RR_EN.
- Defined: round-robin arbitration. A last_grant flip-flop (reset to icache) gives priority to the requester not served last when both request in IDLE.
- Undefined: fixed dcache priority as described under Behaviour.

Decomposition:
- Shared package bmem_pkg holds:
  - localparams LINE_W, BEAT_W, BEATS, OFFSET_W
  - enum adapter_state_t {IDLE, RD_CMD, RD_DATA, WR_DATA, DONE}
  - enum req_src_t {SRC_I, SRC_D}
- One natural sub-module: bmem_arbiter, a 2-requester grant logic holding fixed or round-robin priority and last_grant.

Test Plan:
- icache read 0x0000_1004, memory returns beats 0x11..,0x22..,0x33..,0x44.. with raddr 0x0000_1000 -> bmem_addr=0x0000_1000; one i_resp pulse; i_rdata = {0x44..,0x33..,0x22..,0x11..}.
- dcache write 0x0000_2040 with ready low on beat 2 for 3 cycles -> four write beats in order; beat 2 held stable during the stall; d_resp 1 cycle after beat 3 accepted.
- i_read and d_read both high in the same cycle -> dcache served first, then icache. With BMEM_ARB_RR_EN and last_grant=D, the order is reversed.
- rvalid with raddr 0xDEAD_0000 interleaved mid-burst -> beat ignored; line assembled only from matching beats.
- rst asserted during RD_DATA after 2 beats -> all outputs 0 asynchronously; after release, a new read completes correctly with beat count restarting at 0.
- Back-to-back dcache read after d_resp -> new grant starts no earlier than the cycle after DONE; no duplicate resp.
